// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: opcodes, command word
// layout and the divide/modulo-by-zero predicate.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOTA = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_INC  = 4'b1011;
  localparam logic [3:0] OP_DEC  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_NOR  = 4'b1110;
  localparam logic [3:0] OP_PASB = 4'b1111;

  // One queued ALU command: opcode plus both operands, 12 bits total.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  // True when the command would divide or take a modulo by zero.
  function automatic logic is_div_zero(input logic [3:0] op, input logic [3:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == 4'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO buffering ALU commands ahead of the issue register.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // Storage array: written on push, never reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front end and result capture around an external combinational ALU.
// Pipeline: command FIFO -> issue register (drives the ALU) -> result register.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_res,
  output logic [3:0]       out_op,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int CMD_W = $bits(cmd_t);

  cmd_t             w_in_cmd;
  cmd_t             w_head;
  logic [CMD_W-1:0] w_head_bits;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_adv;
  logic             w_err;

  logic             r_iss_v;
  logic [3:0]       r_alu_op;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic             r_out_valid;
  logic [3:0]       r_out_res;
  logic [3:0]       r_out_op;
  logic             r_out_err;
  logic [ERR_W-1:0] r_err_count;

  assign w_in_cmd = '{op: in_op, a: in_a, b: in_b};
  assign w_head   = cmd_t'(w_head_bits);

  // Ready depends only on stored occupancy (and reset), never on in_valid or a same-cycle pop.
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;

  // The issue stage moves forward whenever the result register is free or being drained.
  assign w_adv = r_iss_v && (!r_out_valid || out_ready);
  assign w_pop = !w_empty && (!r_iss_v || w_adv);
  assign w_err = is_div_zero(r_alu_op, r_alu_b);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_in_cmd),
    .head  (w_head_bits),
    .full  (w_full),
    .empty (w_empty)
  );

  // Issue register: loads the FIFO head on a pop and otherwise holds the ALU inputs steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_v  <= 1'b0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else if (w_pop) begin
      r_iss_v  <= 1'b1;
      r_alu_op <= w_head.op;
      r_alu_a  <= w_head.a;
      r_alu_b  <= w_head.b;
    end else if (w_adv) begin
      r_iss_v  <= 1'b0;
    end
  end

  // Result register: captures the ALU result on advance, zeroing it for division by zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_op    <= '0;
      r_out_err   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= 1'b1;
      r_out_res   <= w_err ? 4'd0 : alu_res;
      r_out_op    <= r_alu_op;
      r_out_err   <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of errored results, bumped as each one is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_adv && w_err && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_op    = r_out_op;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural 4-bit ALU closing the loop.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic [3:0] out_op;
  logic       out_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.DEPTH(4), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_op    (out_op),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; division by zero yields all-ones so the forced zero is observable.
  always_comb begin
    alu_res = 4'd0;
    case (alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_MUL:  alu_res = 4'(alu_a * alu_b);
      OP_DIV:  alu_res = (alu_b == 0) ? 4'hF : alu_a / alu_b;
      OP_MOD:  alu_res = (alu_b == 0) ? 4'hF : alu_a % alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_NOTA: alu_res = ~alu_a;
      OP_SHL:  alu_res = alu_a << alu_b[1:0];
      OP_SHR:  alu_res = alu_a >> alu_b[1:0];
      OP_INC:  alu_res = alu_a + 4'd1;
      OP_DEC:  alu_res = alu_a - 4'd1;
      OP_NAND: alu_res = ~(alu_a & alu_b);
      OP_NOR:  alu_res = ~(alu_a | alu_b);
      default: alu_res = alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command and waits (bounded) for the handshake; reports cycles spent waiting.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                               output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 50; t++) begin
      ok = in_ready;
      tick();
      if (ok) break;
      waited++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: in_ready never seen, waited %0d required <50", waited);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 0; in_a = 0; in_b = 0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({out_valid, out_res, out_op, out_err, err_count} !== 18'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b/%h/%h/%b/%h want all zero", out_valid, out_res, out_op, out_err, err_count);
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== 12'd0) begin
      errors++; $display("[TB] FAIL reset_alu: got %h/%h/%h want 0/0/0", alu_op, alu_a, alu_b);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b want 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL idle_cycle%0d: out_valid %b in_ready %b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_single_add();
    int w;
    applyStimulus(OP_ADD, 4'd7, 4'd5, w);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_lat0: out_valid %b want 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || alu_op !== OP_ADD || alu_a !== 4'd7 || alu_b !== 4'd5) begin
      errors++; $display("[TB] FAIL add_issue: v %b op %h a %h b %h want 0 0 7 5", out_valid, alu_op, alu_a, alu_b);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_res !== 4'hC || out_err !== 1'b0 || out_op !== OP_ADD) begin
      errors++; $display("[TB] FAIL add_result: v %b res %h err %b op %h want 1 C 0 0", out_valid, out_res, out_err, out_op);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_div_zero();
    int w;
    applyStimulus(OP_DIV, 4'd9, 4'd0, w);
    applyStimulus(OP_MOD, 4'd9, 4'd0, w);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_res !== 4'd0 || out_err !== 1'b1 || out_op !== OP_DIV || err_count !== 8'd1) begin
      errors++; $display("[TB] FAIL div0_first: v %b res %h err %b op %h cnt %0d want 1 0 1 3 1", out_valid, out_res, out_err, out_op, err_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_res !== 4'd0 || out_err !== 1'b1 || out_op !== OP_MOD || err_count !== 8'd2) begin
      errors++; $display("[TB] FAIL div0_second: v %b res %h err %b op %h cnt %0d want 1 0 1 4 2", out_valid, out_res, out_err, out_op, err_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd2) begin
      errors++; $display("[TB] FAIL div0_after: v %b cnt %0d want 0 2", out_valid, err_count);
    end
  endtask

  task automatic test_back_to_back();
    int w0, w1, w2;
    applyStimulus(OP_MUL, 4'd3, 4'd3, w0);
    applyStimulus(OP_MUL, 4'd2, 4'd5, w1);
    applyStimulus(OP_MUL, 4'd15, 4'd15, w2);
    checks++;
    if (w0 + w1 + w2 != 0) begin errors++; $display("[TB] FAIL b2b_accept: waited %0d cycles want 0", w0 + w1 + w2); end
    checks++;
    if (out_valid !== 1'b1 || out_res !== 4'd9 || out_op !== OP_MUL) begin
      errors++; $display("[TB] FAIL b2b_r0: v %b res %h op %h want 1 9 2", out_valid, out_res, out_op);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_res !== 4'hA) begin errors++; $display("[TB] FAIL b2b_r1: v %b res %h want 1 A", out_valid, out_res); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_res !== 4'd1) begin errors++; $display("[TB] FAIL b2b_r2: v %b res %h want 1 1", out_valid, out_res); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: v %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(OP_ADD, 4'(i + 1), 4'd3, w);
      checks++;
      if (w != 0) begin errors++; $display("[TB] FAIL bp_push%0d: waited %0d want 0", i, w); end
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== 4'd4 || alu_a !== 4'd2) begin
      errors++; $display("[TB] FAIL bp_full: rdy %b v %b res %h alu_a %h want 0 1 4 2", in_ready, out_valid, out_res, alu_a);
    end
    in_valid = 1'b1; in_op = OP_ADD; in_a = 4'd9; in_b = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_res !== 4'd4 || alu_a !== 4'd2 || alu_b !== 4'd3) begin
        errors++; $display("[TB] FAIL bp_hold%0d: rdy %b res %h a %h b %h want 0 4 2 3", i, in_ready, out_res, alu_a, alu_b);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_res !== 4'(k + 4)) begin
        errors++; $display("[TB] FAIL bp_drain%0d: v %b res %h want 1 %h", k, out_valid, out_res, 4'(k + 4));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_extra: v %b res %h want 0", out_valid, out_res); end
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(OP_SUB, 4'd8, 4'(i), w);
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 4'd0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_state: v %b a %h cnt %0d rdy %b want 0 0 0 0", out_valid, alu_a, err_count, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale%0d: v %b res %h want 0", i, out_valid, out_res); end
    end
  endtask

  task automatic test_err_saturate();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) applyStimulus(OP_DIV, 4'd1, 4'd0, w);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (err_count !== 8'hFF || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL err_saturate: cnt %h v %b want FF 0", err_count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
